// File: rtl/mla_accumulator_mod.sv
// mla_accumulator_mod: framed multiply-accumulate of r*row lanes and r*sum_val over num_rows beats.
// Define MLA_ACC_MODRED_EN to reduce every accumulator modulo MOD_Q instead of wrapping.
module mla_accumulator_mod #(
  parameter int DATA_WIDTH = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_COLS   = 4,
  parameter int R_WIDTH    = 3,
  parameter int CNT_WIDTH  = 16,
  parameter int MOD_Q      = 3329
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             num_rows,
  output logic                             busy,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [R_WIDTH-1:0]        r,
  input  logic [NUM_COLS*DATA_WIDTH-1:0]   row_in,
  input  logic [DATA_WIDTH-1:0]            sum_val,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_COLS*ACC_WIDTH-1:0]    acc_cols,
  output logic [ACC_WIDTH-1:0]             acc_sum
);
  localparam int XW = ACC_WIDTH + DATA_WIDTH + R_WIDTH + 2;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q [NUM_COLS];
  logic [ACC_WIDTH-1:0]   acc_d [NUM_COLS];
  logic [ACC_WIDTH-1:0]   sum_q, sum_d;
  // Full-precision signed sum first, then wrap or reduce to [0, MOD_Q-1].
  function automatic logic [ACC_WIDTH-1:0] f(input logic [ACC_WIDTH-1:0] a,
                                             input logic signed [R_WIDTH-1:0] rv,
                                             input logic [DATA_WIDTH-1:0] d);
    logic signed [XW-1:0] x;
`ifdef MLA_ACC_MODRED_EN
    logic signed [XW-1:0] m;
`endif
    x = $signed({{(XW-ACC_WIDTH){1'b0}}, a}) + XW'(rv) * $signed({{(XW-DATA_WIDTH){1'b0}}, d});
`ifdef MLA_ACC_MODRED_EN
    m = x % $signed(XW'(MOD_Q));
    m = (m < 0) ? m + $signed(XW'(MOD_Q)) : m;
    return ACC_WIDTH'(m);
`else
    return ACC_WIDTH'(x);
`endif
  endfunction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (start) begin
        for (int k = 0; k < NUM_COLS; k++) acc_d[k] = '0;
        sum_d   = '0;
        cnt_d   = num_rows;
        state_d = (num_rows == '0) ? DONE : ACCUM;
      end
      ACCUM: if (in_valid) begin
        for (int k = 0; k < NUM_COLS; k++) acc_d[k] = f(acc_q[k], r, row_in[k*DATA_WIDTH +: DATA_WIDTH]);
        sum_d   = f(sum_q, r, sum_val);
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CNT_WIDTH'(1)) ? DONE : ACCUM;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      for (int k = 0; k < NUM_COLS; k++) acc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      for (int k = 0; k < NUM_COLS; k++) acc_q[k] <= acc_d[k];
    end
  end
  for (genvar g = 0; g < NUM_COLS; g++) begin : g_out
    assign acc_cols[g*ACC_WIDTH +: ACC_WIDTH] = acc_q[g];
  end
  assign acc_sum   = sum_q;
  assign busy      = state_q != IDLE;
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == DONE;
endmodule

// File: tb/tb_mla_accumulator_mod.sv
// tb_mla_accumulator_mod: table-driven transactions plus reset/backpressure sequences for mla_accumulator_mod.
module tb_mla_accumulator_mod;
  logic         clk = 0;
  logic         rst = 0;
  logic         start = 0;
  logic [15:0]  num_rows = 0;
  logic         busy, in_ready, out_valid;
  logic         in_valid = 0;
  logic signed [2:0] r = 0;
  logic [47:0]  row_in = 0;
  logic [11:0]  sum_val = 0;
  logic         out_ready = 0;
  logic [127:0] acc_cols;
  logic [31:0]  acc_sum;
  int checks = 0;
  int errors = 0;

  mla_accumulator_mod dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .r(r), .row_in(row_in), .sum_val(sum_val),
    .out_valid(out_valid), .out_ready(out_ready), .acc_cols(acc_cols), .acc_sum(acc_sum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]       rows;
    logic signed [2:0] r;
    logic [4:0][11:0]  base;
    logic [11:0]       step;
    logic              gap;
    logic              bp;
    logic [4:0][31:0]  exp;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input int rows, input int rv, input int b0, input int b1, input int b2,
                              input int b3, input int b4, input int step, input bit gap, input bit bp,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic [31:0] e4);
    vec_t v;
    v.rows = 16'(rows); v.r = 3'(rv); v.step = 12'(step); v.gap = gap; v.bp = bp;
    v.base[0] = 12'(b0); v.base[1] = 12'(b1); v.base[2] = 12'(b2); v.base[3] = 12'(b3); v.base[4] = 12'(b4);
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_acc(input string name, input logic [4:0][31:0] exp);
    for (int k = 0; k < 4; k++) check($sformatf("%s lane%0d", name, k), acc_cols[k*32 +: 32], exp[k]);
    check($sformatf("%s sum", name), acc_sum, exp[4]);
  endtask

  task automatic run(input int idx, input vec_t v);
    string n;
    n = $sformatf("vec%0d", idx);
    out_ready = !v.bp;
    start = 1; num_rows = v.rows;
    tick();
    start = 0;
    check({n, " busy after start"}, 32'(busy), 1);
    check({n, " in_ready after start"}, 32'(in_ready), 32'(v.rows != 0));
    check({n, " out_valid after start"}, 32'(out_valid), 32'(v.rows == 0));
    for (int b = 0; b < int'(v.rows); b++) begin
      if (v.gap && b > 0) begin
        in_valid = 0;
        tick();
        check({n, " in_ready in gap"}, 32'(in_ready), 1);
      end
      in_valid = 1; r = v.r;
      for (int k = 0; k < 4; k++) row_in[k*12 +: 12] = v.base[k] + 12'(b) * v.step;
      sum_val = v.base[4] + 12'(b) * v.step;
      tick();
      in_valid = 0;
      if (b < int'(v.rows) - 1) check({n, " out_valid mid"}, 32'(out_valid), 0);
    end
    check({n, " out_valid done"}, 32'(out_valid), 1);
    check({n, " in_ready done"}, 32'(in_ready), 0);
    check_acc(n, v.exp);
    if (v.bp) begin
      for (int c = 0; c < 5; c++) begin
        start = (c == 2); num_rows = 16'd5;
        tick();
        start = 0;
        check({n, " bp out_valid"}, 32'(out_valid), 1);
        check({n, " bp in_ready"}, 32'(in_ready), 0);
        check_acc({n, " bp"}, v.exp);
      end
      out_ready = 1;
    end
    tick();
    check({n, " out_valid after handshake"}, 32'(out_valid), 0);
    check({n, " busy after handshake"}, 32'(busy), 0);
    tick();
    check({n, " idle stays idle"}, 32'(busy), 0);
  endtask

  initial begin
    vecs[0] = mk(10, 3, 1, 2, 3, 4, 5, 1, 0, 0, 165, 195, 225, 255, 285);
`ifdef MLA_ACC_MODRED_EN
    vecs[1] = mk(1, -2, 13, 0, 0, 0, 0, 0, 0, 0, 3303, 0, 0, 0, 0);
    vecs[2] = mk(2, 3, 3000, 3000, 3000, 3000, 3000, 0, 0, 0, 1355, 1355, 1355, 1355, 1355);
    vecs[5] = mk(3, -4, 100, 200, 300, 400, 4095, 0, 0, 0, 2129, 929, 3058, 1858, 795);
`else
    vecs[1] = mk(1, -2, 13, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFE6, 0, 0, 0, 0);
    vecs[2] = mk(2, 3, 3000, 3000, 3000, 3000, 3000, 0, 0, 0, 18000, 18000, 18000, 18000, 18000);
    vecs[5] = mk(3, -4, 100, 200, 300, 400, 4095, 0, 0, 0, -1200, -2400, -3600, -4800, -49140);
`endif
    vecs[3] = mk(4, 1, 10, 20, 30, 40, 50, 1, 1, 1, 46, 86, 126, 166, 206);
    vecs[4] = mk(0, 1, 5, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 0;
    tick(); tick();
    check("reset busy", 32'(busy), 0);
    check("reset in_ready", 32'(in_ready), 0);
    check("reset out_valid", 32'(out_valid), 0);
    check_acc("reset", '0);
    rst = 1;
    tick();

    for (int i = 0; i < 6; i++) run(i, vecs[i]);

    // Reset after 3 of 8 beats, then a fresh single-beat transaction.
    out_ready = 1;
    start = 1; num_rows = 16'd8;
    tick();
    start = 0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1; r = 3'sd2; row_in = {12'd4, 12'd3, 12'd2, 12'd1}; sum_val = 12'd9;
      tick();
    end
    in_valid = 0;
    check("pre-reset lane0 accumulated", acc_cols[31:0], 6);
    rst = 0;
    tick();
    rst = 1;
    check("midreset busy", 32'(busy), 0);
    check("midreset in_ready", 32'(in_ready), 0);
    check("midreset out_valid", 32'(out_valid), 0);
    check_acc("midreset", '0);
    run(6, mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
